boreal_spatial_projector: RTL
=============================

Name: boreal_spatial_projector

Overview:
- Parametrised multi-channel spatial projector. Accumulates one weighted dot product per feature over a frame of N_CH time-multiplexed channel samples, then emits N_FEAT saturated features per frame.
- Successor to the fixed 8-channel, 2-feature extractor. Adds runtime-loadable double-banked weights, explicit frame sync, output valid/ready backpressure, saturation flags and a frame counter.
- Sits between the front-end channel multiplexer and the downstream cursor/decoder logic.

Parameters:
- N_CH, 8, channels per frame (≥2).
- N_FEAT, 2, features produced per frame (≥1).
- DW, 16, signed sample and feature width.
- WW, 8, signed weight width.
- OUT_SHIFT, 8, arithmetic right shift applied to the accumulator before saturation.
- ACC_W, 32, accumulator width. Must be ≥ DW+WW+clog2(N_CH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&&s_ready
- s_data  in  DW  signed channel sample
- s_first  in  1  marks channel 0 of a frame
- m_valid  out  1  feature vector valid
- m_ready  in  1  downstream accepts
- m_data  out  N_FEAT*DW  features; feature f occupies bits [f*DW +: DW]
- m_sat  out  N_FEAT  per-feature saturation flag, aligned with m_data
- frame_err  out  1  one-cycle pulse on a sync violation
- frame_cnt  out  16  count of emitted frames, wraps at 2^16
- w_we  in  1  weight write strobe to the shadow bank
- w_feat  in  clog2(N_FEAT)  weight feature index
- w_ch  in  clog2(N_CH)  weight channel index
- w_data  in  WW  signed weight value
- w_commit  in  1  request to swap the active and shadow banks
- w_busy  out  1  commit pending

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: ch=0, all accumulators 0, m_valid=0, m_data=0, m_sat=0, frame_err=0, frame_cnt=0, w_busy=0, both weight banks all-zero, active bank index=0.
- Reset mid-frame discards the partial accumulation. Reset mid-handshake drops the held output.
- Accept rule: s_ready = !(ch==N_CH-1 && m_valid && !m_ready). Backpressure therefore stalls only the last channel of a frame.
- Per accepted sample, for every feature f: acc[f] += s_data * Wactive[f][ch]. The product is full-precision signed, sign-extended to ACC_W.
- Sync, accepted sample with s_first=1 and ch≠0:
  - pulse frame_err;
  - discard the partial frame;
  - treat the sample as channel 0, so acc[f] = product only.
- Sync, accepted sample with s_first=0 and ch==0: pulse frame_err, discard the sample, ch remains 0.
- Frame completion, when the ch==N_CH-1 sample is accepted:
  - result[f] = (acc[f] + product) >>> OUT_SHIFT;
  - saturate result[f] to the signed DW range and set m_sat[f] if clipped;
  - load m_data and m_sat, set m_valid on the next edge (latency 1 cycle from the last accepted sample);
  - clear the accumulators, set ch=0, increment frame_cnt.
- Output hold: m_valid stays high and m_data/m_sat stay stable until m_valid&&m_ready. The output clears on that edge unless a new frame completes on the same edge, in which case the new vector loads and m_valid stays 1.
- Weights, writing: w_we writes w_data to the shadow bank at [w_feat][w_ch]. Out-of-range indices are ignored. w_we is ignored while w_busy=1.
- Weights, committing: w_commit sets w_busy. The swap executes on the edge that completes a frame, or on any edge where ch==0 and no sample is accepted. w_busy clears on the swap edge.
- A frame always uses a single bank throughout. After the swap, the shadow bank holds the previous active weights.
- w_commit while already busy has no additional effect.

Decomposition:
- Package boreal_fx_pkg holds:
  - width helpers (clog2);
  - the saturate-to-DW function;
  - the feature-slice index macro/constants;
  - default OUT_SHIFT.
- Sub-module boreal_weight_bank:
  - double-banked N_FEAT×N_CH×WW register array;
  - shadow write port, combinational active read by ch;
  - swap handshake (commit/pending/swap_en).
- The top level holds the channel counter, accumulators, sync checking and the output register.

Test Plan:
- Load W0=[10,8,6,4,-4,-6,-8,-10] and W1=[-4,-2,2,4,10,8,-8,-10], commit; send a frame with ch0=1000 and the rest 0 -> m_data={f1=-16, f0=39}, m_sat=0, frame_cnt=1, m_valid one cycle after the last sample.
- Set all weights of feature 0 to 127; send a frame of all 32767 -> f0=32767, m_sat[0]=1; repeat with all -32768 -> f0=-32768, m_sat[0]=1.
- Hold m_ready=0 across two frames -> second frame's channel 7 sees s_ready=0 and first vector held unchanged; raise m_ready -> first vector accepted, then second frame completes, no data loss.
- Assert s_first at ch=5 -> one-cycle frame_err, no output for the partial frame, following frame correct. Send a sample with s_first=0 at ch=0 -> frame_err, sample ignored.
- Commit new weights at ch=3 -> w_busy=1, w_we ignored, current frame uses old weights, swap on completion, next frame uses new weights, w_busy=0.
- Assert rst at ch=4 with m_valid=1 -> all outputs return to reset values; the next full frame produces the correct result from zero weights (0,0).

Source files
------------

// File: rtl/boreal_fx_pkg.sv
// Shared fixed-point helpers for the boreal spatial projector.
//   - idx_w / clog2 : index-width helpers (idx_w never returns 0)
//   - feat_lo       : low bit of feature f in a packed feature vector
//   - sat_dw        : clip a wide signed value to a signed dw-bit range
//   - DEF_OUT_SHIFT : default accumulator-to-output arithmetic shift
package boreal_fx_pkg;

  localparam int unsigned DEF_OUT_SHIFT = 8;
  localparam int unsigned SAT_W         = 64;

  typedef struct packed {
    logic                    hit;
    logic signed [SAT_W-1:0] val;
  } sat_t;

  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned feat_lo(input int unsigned f, input int unsigned dw);
    return f * dw;
  endfunction

  // Input must already be sign-extended to SAT_W; dw must be <= SAT_W-1.
  function automatic sat_t sat_dw(input logic signed [SAT_W-1:0] v, input int unsigned dw);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t                    r;
    hi    = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (dw - 1));
    r.hit = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.hit = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.hit = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/boreal_weight_bank.sv
// Double-banked weight store for the spatial projector.
//   we/wr_feat/wr_ch/wr_data : write into the shadow bank (ignored while busy
//                              or when an index is out of range)
//   commit                   : request an active/shadow swap, sets busy
//   swap_en                  : edge on which a pending swap may execute
//   rd_ch / rd_w             : combinational read of all feature weights of
//                              the active bank for one channel
//   busy                     : swap pending
module boreal_weight_bank
  import boreal_fx_pkg::*;
#(
  parameter int unsigned N_FEAT = 2,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned WW     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [idx_w(N_FEAT)-1:0]    wr_feat,
  input  logic [idx_w(N_CH)-1:0]      wr_ch,
  input  logic signed [WW-1:0]        wr_data,
  input  logic                        commit,
  input  logic                        swap_en,
  input  logic [idx_w(N_CH)-1:0]      rd_ch,
  output logic [N_FEAT*WW-1:0]        rd_w,
  output logic                        busy
);

  logic signed [WW-1:0] bank [2][N_FEAT][N_CH];
  logic                 sel;
  logic                 shadow;
  logic                 wr_ok;

  assign shadow = ~sel;
  assign wr_ok  = we && !busy && (32'(wr_feat) < N_FEAT) && (32'(wr_ch) < N_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel  <= 1'b0;
      busy <= 1'b0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned f = 0; f < N_FEAT; f++)
          for (int unsigned c = 0; c < N_CH; c++)
            bank[b][f][c] <= '0;
    end else begin
      // Flipping the select leaves the old active weights in the shadow bank.
      if (busy && swap_en) begin
        sel  <= ~sel;
        busy <= 1'b0;
      end else if (commit) begin
        busy <= 1'b1;
      end
      if (wr_ok)
        bank[shadow][wr_feat][wr_ch] <= wr_data;
    end
  end

  always_comb begin
    rd_w = '0;
    for (int unsigned f = 0; f < N_FEAT; f++)
      rd_w[f*WW +: WW] = bank[sel][f][rd_ch];
  end

endmodule

// File: rtl/boreal_spatial_projector.sv
// Multi-channel spatial projector: accumulates one weighted dot product per
// feature over a frame of N_CH time-multiplexed samples and emits N_FEAT
// saturated features per frame.
//   s_valid/s_ready/s_data/s_first : channel sample stream, s_first marks ch 0
//   m_valid/m_ready/m_data/m_sat   : feature vector with per-feature clip flags
//   frame_err                      : one-cycle pulse on a sync violation
//   frame_cnt                      : emitted frame count (wraps)
//   w_we/w_feat/w_ch/w_data        : shadow weight write port
//   w_commit/w_busy                : bank swap request / pending
module boreal_spatial_projector
  import boreal_fx_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned N_FEAT    = 2,
  parameter int unsigned DW        = 16,
  parameter int unsigned WW        = 8,
  parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DW-1:0]      s_data,
  input  logic                      s_first,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N_FEAT*DW-1:0]      m_data,
  output logic [N_FEAT-1:0]         m_sat,
  output logic                      frame_err,
  output logic [15:0]               frame_cnt,
  input  logic                      w_we,
  input  logic [idx_w(N_FEAT)-1:0]  w_feat,
  input  logic [idx_w(N_CH)-1:0]    w_ch,
  input  logic signed [WW-1:0]      w_data,
  input  logic                      w_commit,
  output logic                      w_busy
);

  localparam int unsigned    CW      = idx_w(N_CH);
  localparam logic [CW-1:0]  LAST_CH = CW'(N_CH - 1);

  logic [CW-1:0]            ch;
  logic [CW-1:0]            rd_ch;
  logic                     at_first;
  logic                     at_last;
  logic                     accept;
  logic                     sync_restart;
  logic                     sync_drop;
  logic                     complete;
  logic                     swap_en;
  logic [N_FEAT*WW-1:0]     rd_w;
  logic signed [ACC_W-1:0]  acc      [N_FEAT];
  logic signed [ACC_W-1:0]  prod_ext [N_FEAT];
  logic [DW-1:0]            res      [N_FEAT];
  logic [N_FEAT-1:0]        hit;

  assign at_first     = (ch == '0);
  assign at_last      = (ch == LAST_CH);
  assign s_ready      = !(at_last && m_valid && !m_ready);
  assign accept       = s_valid && s_ready;
  assign sync_restart = accept && s_first && !at_first;
  assign sync_drop    = accept && !s_first && at_first;
  // s_first on the last channel is a restart, not a completion.
  assign complete     = accept && at_last && !s_first;
  assign swap_en      = complete || (at_first && !accept);
  // A restarting sample is weighted as channel 0.
  assign rd_ch        = s_first ? '0 : ch;

  boreal_weight_bank #(
    .N_FEAT (N_FEAT),
    .N_CH   (N_CH),
    .WW     (WW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (w_we),
    .wr_feat (w_feat),
    .wr_ch   (w_ch),
    .wr_data (w_data),
    .commit  (w_commit),
    .swap_en (swap_en),
    .rd_ch   (rd_ch),
    .rd_w    (rd_w),
    .busy    (w_busy)
  );

  for (genvar g = 0; g < N_FEAT; g++) begin : g_feat
    logic signed [WW-1:0]    w;
    logic signed [DW+WW-1:0] prod;
    logic signed [ACC_W-1:0] shifted;
    sat_t                    sat;

    assign w           = rd_w[g*WW +: WW];
    assign prod        = (DW+WW)'(s_data) * (DW+WW)'(w);
    assign prod_ext[g] = ACC_W'(prod);
    assign shifted     = (acc[g] + prod_ext[g]) >>> OUT_SHIFT;
    assign sat         = sat_dw(SAT_W'(shifted), DW);
    assign res[g]      = sat.val[DW-1:0];
    assign hit[g]      = sat.hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sat     <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      for (int unsigned f = 0; f < N_FEAT; f++)
        acc[f] <= '0;
    end else begin
      frame_err <= sync_restart || sync_drop;

      if (sync_restart) begin
        for (int unsigned f = 0; f < N_FEAT; f++)
          acc[f] <= prod_ext[f];
        ch <= CW'(1);
      end else if (complete) begin
        for (int unsigned f = 0; f < N_FEAT; f++)
          acc[f] <= '0;
        ch        <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (accept && !sync_drop) begin
        for (int unsigned f = 0; f < N_FEAT; f++)
          acc[f] <= acc[f] + prod_ext[f];
        ch <= ch + 1'b1;
      end

      // A completing frame can only be accepted when the held vector is
      // leaving on the same edge, so loading takes priority over clearing.
      if (complete) begin
        m_valid <= 1'b1;
        m_sat   <= hit;
        for (int unsigned f = 0; f < N_FEAT; f++)
          m_data[feat_lo(f, DW) +: DW] <= res[f];
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        m_sat   <= '0;
      end
    end
  end

endmodule
